// File: rtl/pe_mac_dbuf_if.sv
// Bundle of the dataflow, weight-chain and overflow signals of one MAC cell.
// The master drives the cell inputs; the slave is the cell itself.
interface pe_mac_dbuf_if #(
    parameter int A_W  = 8,
    parameter int W_W  = 8,
    parameter int PS_W = 24
) ();
    logic [A_W-1:0]  in_a;
    logic            in_valid;
    logic [PS_W-1:0] in_psum;
    logic [A_W-1:0]  out_a;
    logic [PS_W-1:0] out_psum;
    logic            out_valid;
    logic            w_load;
    logic [W_W-1:0]  w_in;
    logic [W_W-1:0]  w_out;
    logic            w_load_out;
    logic            w_swap;
    logic            w_swap_out;
    logic            ovf;
    logic            ovf_clr;

    modport master (
        output in_a, in_valid, in_psum, w_load, w_in, w_swap, ovf_clr,
        input  out_a, out_psum, out_valid, w_out, w_load_out, w_swap_out, ovf
    );

    modport slave (
        input  in_a, in_valid, in_psum, w_load, w_in, w_swap, ovf_clr,
        output out_a, out_psum, out_valid, w_out, w_load_out, w_swap_out, ovf
    );
endinterface

// File: rtl/pe_mac_dbuf.sv
// Weight-stationary MAC cell with a double-buffered weight: a shadow weight
// shifts in on a daisy chain while the active weight keeps computing.
module pe_mac_dbuf #(
    parameter int A_W      = 8,
    parameter int W_W      = 8,
    parameter int PS_W     = 24,
    parameter bit SIGNED   = 1'b1,
    parameter bit SATURATE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    pe_mac_dbuf_if.slave       bus
);
    localparam int PROD_W = A_W + W_W + 2;
    // Two guard bits keep both signed and unsigned sums exact in one signed type.
    localparam int EXT_W  = PS_W + 2;
    localparam logic signed [EXT_W-1:0] ONE   = {{(EXT_W-1){1'b0}}, 1'b1};
    localparam logic signed [EXT_W-1:0] MAX_V = SIGNED ? ((ONE <<< (PS_W-1)) - ONE)
                                                       : ((ONE <<< PS_W) - ONE);
    localparam logic signed [EXT_W-1:0] MIN_V = SIGNED ? -(ONE <<< (PS_W-1)) : '0;

    logic [A_W-1:0]  a_q;
    logic [PS_W-1:0] psum_q, psum_d;
    logic            valid_q;
    logic [W_W-1:0]  shadow_q;
    logic [W_W-1:0]  w_act_q;
    logic            w_load_q;
    logic            w_swap_q;
    logic            ovf_q, ovf_d;

    logic signed [A_W:0]        a_e;
    logic signed [W_W:0]        w_e;
    logic signed [EXT_W-1:0]    ps_e;
    logic signed [PROD_W-1:0]   prod;
    logic signed [EXT_W-1:0]    sum_x;
    logic                       ovf_now;

    generate
        if (SIGNED) begin : g_sext
            assign a_e  = {bus.in_a[A_W-1], bus.in_a};
            assign w_e  = {w_act_q[W_W-1], w_act_q};
            assign ps_e = EXT_W'(signed'(bus.in_psum));
        end else begin : g_zext
            assign a_e  = {1'b0, bus.in_a};
            assign w_e  = {1'b0, w_act_q};
            assign ps_e = EXT_W'(bus.in_psum);
        end
    endgenerate

    assign prod  = PROD_W'(a_e) * PROD_W'(w_e);
    assign sum_x = EXT_W'(prod) + ps_e;

    always_comb begin
        ovf_now = (sum_x > MAX_V) || (sum_x < MIN_V);
        psum_d  = sum_x[PS_W-1:0];
        if (ovf_now && SATURATE) begin
            psum_d = (sum_x > MAX_V) ? MAX_V[PS_W-1:0] : MIN_V[PS_W-1:0];
        end
        // A fresh overflow outranks a simultaneous clear.
        ovf_d = (ovf_q && !bus.ovf_clr) || (bus.in_valid && ovf_now);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            psum_q   <= '0;
            valid_q  <= 1'b0;
            shadow_q <= '0;
            w_act_q  <= '0;
            w_load_q <= 1'b0;
            w_swap_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                a_q    <= bus.in_a;
                psum_q <= psum_d;
            end
            valid_q  <= bus.in_valid;
            if (bus.w_load) shadow_q <= bus.w_in;
            if (bus.w_swap) w_act_q  <= shadow_q;
            w_load_q <= bus.w_load;
            w_swap_q <= bus.w_swap;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.out_a      = a_q;
    assign bus.out_psum   = psum_q;
    assign bus.out_valid  = valid_q;
    assign bus.w_out      = shadow_q;
    assign bus.w_load_out = w_load_q;
    assign bus.w_swap_out = w_swap_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_pe_mac_dbuf.sv
// Bench for pe_mac_dbuf: three configurations driven in lockstep and compared
// against an arithmetic model of the cell after every clock.
module tb_pe_mac_dbuf;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_mac_dbuf_if #(.A_W(8), .W_W(8), .PS_W(24)) if0 ();
    pe_mac_dbuf_if #(.A_W(8), .W_W(8), .PS_W(16)) if1 ();
    pe_mac_dbuf_if #(.A_W(8), .W_W(8), .PS_W(16)) if2 ();

    pe_mac_dbuf #(.A_W(8), .W_W(8), .PS_W(24), .SIGNED(1'b1), .SATURATE(1'b1))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    pe_mac_dbuf #(.A_W(8), .W_W(8), .PS_W(16), .SIGNED(1'b1), .SATURATE(1'b1))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    pe_mac_dbuf #(.A_W(8), .W_W(8), .PS_W(16), .SIGNED(1'b0), .SATURATE(1'b0))
        u2 (.clk(clk), .rst(rst), .bus(if2));

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    int psw_c[3] = '{24, 16, 16};
    bit sgn_c[3] = '{1'b1, 1'b1, 1'b0};
    bit sat_c[3] = '{1'b1, 1'b1, 1'b0};

    logic [7:0]  shadow_m, wact_m;
    bit          wl_m, ws_m;
    logic [7:0]  a_m[3];
    logic [23:0] ps_m[3];
    bit          v_m[3];
    bit          ov_m[3];

    function automatic logic [23:0] calc(input int psw, input bit sgn, input bit sat,
                                         input logic [23:0] ps_raw, input logic [7:0] a,
                                         input logic [7:0] w, output bit ov);
        longint av, wv, pv, s, mx, mn, r, m;
        m  = (longint'(1) << psw) - 1;
        av = sgn ? longint'($signed(a)) : longint'(a);
        wv = sgn ? longint'($signed(w)) : longint'(w);
        pv = longint'(ps_raw) & m;
        if (sgn && pv[psw-1]) pv = pv - (m + 1);
        s  = pv + av * wv;
        mx = sgn ? (m >> 1) : m;
        mn = sgn ? (-(m >> 1) - 1) : 0;
        ov = (s > mx) || (s < mn);
        r  = (sat && ov) ? ((s > mx) ? mx : mn) : s;
        return 24'(r & m);
    endfunction

    task automatic model_reset();
        shadow_m = '0; wact_m = '0; wl_m = 0; ws_m = 0;
        for (int k = 0; k < 3; k++) begin
            a_m[k] = '0; ps_m[k] = '0; v_m[k] = 0; ov_m[k] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input string tag, input int k, input logic v, input logic [7:0] a,
                            input logic [23:0] p, input logic o, input logic [7:0] wo,
                            input logic wlo, input logic wso);
        chk($sformatf("%s.u%0d.valid", tag, k), 64'(v), 64'(v_m[k]));
        chk($sformatf("%s.u%0d.a", tag, k), 64'(a), 64'(a_m[k]));
        chk($sformatf("%s.u%0d.psum", tag, k), 64'(p), 64'(ps_m[k]));
        chk($sformatf("%s.u%0d.ovf", tag, k), 64'(o), 64'(ov_m[k]));
        chk($sformatf("%s.u%0d.w_out", tag, k), 64'(wo), 64'(shadow_m));
        chk($sformatf("%s.u%0d.w_load_out", tag, k), 64'(wlo), 64'(wl_m));
        chk($sformatf("%s.u%0d.w_swap_out", tag, k), 64'(wso), 64'(ws_m));
    endtask

    task automatic check_all(input string tag);
        chk_inst(tag, 0, if0.out_valid, if0.out_a, if0.out_psum, if0.ovf,
                 if0.w_out, if0.w_load_out, if0.w_swap_out);
        chk_inst(tag, 1, if1.out_valid, if1.out_a, 24'(if1.out_psum), if1.ovf,
                 if1.w_out, if1.w_load_out, if1.w_swap_out);
        chk_inst(tag, 2, if2.out_valid, if2.out_a, 24'(if2.out_psum), if2.ovf,
                 if2.w_out, if2.w_load_out, if2.w_swap_out);
    endtask

    task automatic step(input string tag, input bit v, input logic [7:0] a,
                        input logic [23:0] ps, input bit wl, input logic [7:0] wi,
                        input bit ws, input bit clr);
        bit o;
        logic [23:0] r;
        if0.in_valid = v; if0.in_a = a; if0.in_psum = ps;
        if0.w_load = wl; if0.w_in = wi; if0.w_swap = ws; if0.ovf_clr = clr;
        if1.in_valid = v; if1.in_a = a; if1.in_psum = ps[15:0];
        if1.w_load = wl; if1.w_in = wi; if1.w_swap = ws; if1.ovf_clr = clr;
        if2.in_valid = v; if2.in_a = a; if2.in_psum = ps[15:0];
        if2.w_load = wl; if2.w_in = wi; if2.w_swap = ws; if2.ovf_clr = clr;
        for (int k = 0; k < 3; k++) begin
            r = calc(psw_c[k], sgn_c[k], sat_c[k], ps, a, wact_m, o);
            if (v) begin
                a_m[k]  = a;
                ps_m[k] = r;
            end
            v_m[k]  = v;
            ov_m[k] = (ov_m[k] && !clr) || (v && o);
        end
        if (ws) wact_m = shadow_m;
        if (wl) shadow_m = wi;
        wl_m = wl;
        ws_m = ws;
        @(posedge clk);
        #1;
        cyc_n++;
        $display("cyc %0d %s: v=%0b a=%02h ps=%06h wl=%0b wi=%02h ws=%0b clr=%0b -> p0=%06h p1=%04h p2=%04h ovf=%0b%0b%0b",
                 cyc_n, tag, v, a, ps, wl, wi, ws, clr,
                 if0.out_psum, if1.out_psum, if2.out_psum, if0.ovf, if1.ovf, if2.ovf);
        check_all(tag);
    endtask

    task automatic load_swap(input logic [7:0] w);
        step("load", 0, 8'h00, 24'h0, 1, w, 0, 0);
        step("swap", 0, 8'h00, 24'h0, 0, 8'h00, 1, 0);
    endtask

    initial begin
        model_reset();
        if0.in_valid = 0; if0.in_a = '0; if0.in_psum = '0; if0.w_load = 0; if0.w_in = '0; if0.w_swap = 0; if0.ovf_clr = 0;
        if1.in_valid = 0; if1.in_a = '0; if1.in_psum = '0; if1.w_load = 0; if1.w_in = '0; if1.w_swap = 0; if1.ovf_clr = 0;
        if2.in_valid = 0; if2.in_a = '0; if2.in_psum = '0; if2.w_load = 0; if2.w_in = '0; if2.w_swap = 0; if2.ovf_clr = 0;
        #2;
        check_all("reset");
        #10;
        rst = 1'b1;
        step("idle", 0, 8'h00, 24'h0, 0, 8'h00, 0, 0);
        step("idle", 0, 8'h00, 24'h0, 0, 8'h00, 0, 0);

        // Load 3, swap, compute -5*3+100.
        step("t2_load", 0, 8'h00, 24'h0, 1, 8'd3, 0, 0);
        chk("t2_w_out", 64'(if0.w_out), 64'd3);
        chk("t2_w_load_out", 64'(if0.w_load_out), 64'd1);
        step("t2_swap", 0, 8'h00, 24'h0, 0, 8'h00, 1, 0);
        step("t2_mac", 1, 8'hFB, 24'd100, 0, 8'h00, 0, 0);
        chk("t2_psum", 64'(if0.out_psum), 64'd85);

        // Shadow loads 7 while the active weight 2 keeps computing.
        load_swap(8'd2);
        step("t3_a", 1, 8'd1, 24'd0, 1, 8'd7, 0, 0);
        chk("t3_psum_a", 64'(if0.out_psum), 64'd2);
        step("t3_b", 1, 8'd1, 24'd0, 0, 8'h00, 1, 0);
        chk("t3_psum_b", 64'(if0.out_psum), 64'd2);
        step("t3_c", 1, 8'd1, 24'd0, 0, 8'h00, 0, 0);
        chk("t3_psum_c", 64'(if0.out_psum), 64'd7);

        // Signed saturation on the 16-bit cell, then clear behaviour.
        load_swap(8'd127);
        step("t4_sat", 1, 8'd127, 24'd32700, 0, 8'h00, 0, 0);
        chk("t4_psum", 64'(if1.out_psum), 64'd32767);
        chk("t4_ovf", 64'(if1.ovf), 64'd1);
        step("t4_clr_ovf", 1, 8'd127, 24'd32700, 0, 8'h00, 0, 1);
        chk("t4_ovf_hold", 64'(if1.ovf), 64'd1);
        step("t4_clr", 0, 8'h00, 24'h0, 0, 8'h00, 0, 1);
        chk("t4_ovf_clr", 64'(if1.ovf), 64'd0);

        // Unsigned wrap on the 16-bit cell.
        load_swap(8'd1);
        step("t5_wrap", 1, 8'd1, 24'd65535, 0, 8'h00, 0, 0);
        chk("t5_psum", 64'(if2.out_psum), 64'd0);
        chk("t5_ovf", 64'(if2.ovf), 64'd1);
        step("t5_clr", 0, 8'h00, 24'h0, 0, 8'h00, 0, 1);

        // Simultaneous load and swap.
        step("t6_load", 0, 8'h00, 24'h0, 1, 8'd4, 0, 0);
        step("t6_both", 0, 8'h00, 24'h0, 1, 8'd9, 1, 0);
        chk("t6_w_out", 64'(if0.w_out), 64'd9);
        step("t6_mac", 1, 8'd2, 24'd0, 0, 8'h00, 0, 0);
        chk("t6_psum", 64'(if0.out_psum), 64'd8);

        for (int i = 0; i < 80; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom), 24'($urandom),
                 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset between clock edges.
        step("pre_rst", 1, 8'h5A, 24'h001234, 1, 8'h3C, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #3;
        rst = 1'b1;
        step("post_rst", 0, 8'h00, 24'h0, 0, 8'h00, 0, 0);
        step("post_rst", 0, 8'h00, 24'h0, 0, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pe_mac_dbuf.md
Name: pe_mac_dbuf

Overview:
- Parametrised successor to the systolic-array processing element. Weight-stationary MAC cell with a double-buffered weight register: the next weight tile shifts in through a daisy chain while the current tile keeps computing.
- Adds valid-tagged dataflow, signed/unsigned mode, a wider partial-sum path, optional saturation and a sticky overflow flag.
- Tiled N x M in the array. Activations flow west to east, partial sums flow north to south, and weights shift down columns on a separate chain.

Parameters:
A_W, 8, activation width
W_W, 8, weight width
PS_W, 24, partial-sum width; must satisfy PS_W >= A_W+W_W
SIGNED, 1, 1 = two's-complement operands and psum, 0 = unsigned
SATURATE, 1, 1 = clamp psum on overflow, 0 = wrap modulo 2^PS_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
in_a  in  A_W  activation from west
in_valid  in  1  in_a and in_psum valid this cycle
in_psum  in  PS_W  partial sum from north
out_a  out  A_W  activation to east
out_psum  out  PS_W  partial sum to south
out_valid  out  1  out_a/out_psum valid
w_load  in  1  shift w_in into the shadow weight this cycle
w_in  in  W_W  weight chain input from north
w_out  out  W_W  weight chain output to south (registered shadow)
w_load_out  out  1  w_load delayed 1 cycle, for the next cell
w_swap  in  1  copy shadow to active weight
w_swap_out  out  1  w_swap delayed 1 cycle, for the next cell
ovf  out  1  sticky overflow/saturation flag
ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset (rst=0, async): out_a, out_psum, w_out, the active weight and the shadow weight are cleared to 0; out_valid, w_load_out, w_swap_out and ovf are cleared to 0. Reset mid-operation drops in-flight data; there is no recovery beyond a fresh load.
- Compute, 1-cycle latency. If in_valid=1 at edge k, then at edge k:
  - out_a <= in_a
  - out_psum <= f(in_psum + in_a*w_act)
  - out_valid <= 1
- If in_valid=0: out_valid <= 0; out_a and out_psum hold their previous values.
- Arithmetic, SIGNED=1:
  - Operands are sign-extended.
  - The product is A_W+W_W bits, sign-extended to PS_W+1.
  - The sum is computed at PS_W+1 bits.
- Arithmetic, SIGNED=0: same widths, with zero-extension.
- Overflow condition: the PS_W+1 result is not representable in PS_W bits.
- f with SATURATE=1 on overflow: clamp to 2^(PS_W-1)-1 or -2^(PS_W-1) when signed, or to 2^PS_W-1 when unsigned.
- f with SATURATE=0 on overflow: truncate to the low PS_W bits.
- Overflow with in_valid=1 sets ovf in both SATURATE modes.
- ovf behaviour:
  - Cleared by ovf_clr=1.
  - A set in the same cycle as ovf_clr wins, so ovf=1.
  - Overflow with in_valid=0 is ignored.
- Weight chain:
  - When w_load=1: shadow <= w_in, and w_out is the shadow register itself.
  - w_load_out <= w_load each cycle.
  - The chain runs independently of compute; loading never stalls or disturbs out_psum.
  - For a column of R cells, drive R consecutive w_load cycles with the bottom-row weight first.
- Swap:
  - When w_swap=1 at edge k: w_act <= shadow, effective for the compute at edge k+1 onward.
  - A compute at edge k itself uses the old w_act.
  - w_swap_out <= w_swap each cycle.
- Simultaneous w_load and w_swap: w_act takes the pre-edge shadow, and the shadow takes w_in.
- No state machine is required beyond these registers. All control is level/pulse per cycle, with no back-pressure.

Test Plan:
1. Reset and idle: assert rst=0 asynchronously mid-cycle -> all outputs are 0 immediately. Release rst and hold in_valid=0 -> out_valid stays 0 and out_psum stays 0.
2. Load, swap, compute (SIGNED=1): w_load with w_in=3 for 1 cycle, then w_swap, then in_a=-5 (0xFB), in_psum=100, in_valid=1 -> next cycle out_psum=85, out_a=0xFB, out_valid=1. w_out=3 and w_load_out=1 one cycle after the load.
3. Double buffer: w_act=2; load shadow=7 while streaming in_a=1,1,1 with in_psum=0; w_swap on the 2nd compute edge -> out_psum=2,2,7.
4. Saturation (PS_W=16, SIGNED=1, SATURATE=1): in_psum=32700, in_a=127, w_act=127 -> out_psum=32767, ovf=1. ovf_clr in the same cycle as another overflow -> ovf stays 1. A later ovf_clr alone -> 0.
5. Unsigned wrap (SIGNED=0, SATURATE=0, PS_W=16): in_psum=65535, in_a=1, w=1 -> out_psum=0, ovf=1.
6. Simultaneous load and swap: shadow=4, w_in=9, w_load=1 and w_swap=1 -> w_act=4, shadow=w_out=9. The next compute with in_a=2, in_psum=0 gives 8.
